// File: rtl/trace_pkg.sv
// Shared definitions for the architectural-state tracer: FSM encoding and beat tags.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PC   = 2'd1,
    ST_REGS = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int TAG_PC = 0;

endpackage

// File: rtl/trace_dump_unit.sv
// Snapshots the PC on each retired instruction, walks the register file through a
// dedicated read port and streams one valid/ready record while holding the CPU stalled.
module trace_dump_unit
  import trace_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_REGS    = 32,
  parameter int DUMP_REGS   = 1,
  parameter int MAX_RECORDS = 30,
  parameter int CNT_W       = 16,
  localparam int AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             commit_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic [AW-1:0]    rf_addr_o,
  input  logic [XLEN-1:0]  rf_data_i,
  output logic             stall_o,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [XLEN-1:0]  trace_data_o,
  output logic [AW:0]      trace_tag_o,
  output logic             trace_last_o,
  output logic [CNT_W-1:0] record_cnt_o,
  output logic             done_o,
  output logic             overflow_o
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             stall_q, stall_d;

  logic             busy;
  logic             fire;
  logic             last_beat;
  logic             rec_done;
  logic [CNT_W-1:0] cnt_inc;

  assign busy     = (state_q == ST_PC) || (state_q == ST_REGS);
  assign fire     = busy && trace_ready_i;
  assign rec_done = fire && last_beat;

  always_comb begin
    last_beat = 1'b0;
    if (state_q == ST_PC) begin
      last_beat = (DUMP_REGS == 0);
    end else if (state_q == ST_REGS) begin
      last_beat = (idx_q == AW'(NUM_REGS - 1));
    end
  end

  // An unlimited trace sticks at all-ones rather than wrapping back to zero.
  always_comb begin
    if ((MAX_RECORDS == 0) && (&cnt_q)) begin
      cnt_inc = cnt_q;
    end else begin
      cnt_inc = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q | (busy & commit_i);

    case (state_q)
      ST_IDLE: begin
        if (commit_i && enable_i) begin
          pc_d    = pc_i;
          state_d = ST_PC;
        end
      end
      ST_PC: begin
        if (fire && (DUMP_REGS != 0)) begin
          idx_d   = '0;
          state_d = ST_REGS;
        end
      end
      ST_REGS: begin
        if (fire && !last_beat) begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (rec_done) begin
      cnt_d = cnt_inc;
      idx_d = '0;
      if ((MAX_RECORDS != 0) && (cnt_inc == CNT_W'(MAX_RECORDS))) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_IDLE;
      end
    end

    stall_d = (state_d == ST_PC) || (state_d == ST_REGS);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      stall_q <= stall_d;
    end
  end

  // Beat mux: outputs are idle-zero so nothing leaks outside a record.
  always_comb begin
    rf_addr_o    = '0;
    trace_data_o = '0;
    trace_tag_o  = '0;
    trace_last_o = 1'b0;
    if (state_q == ST_PC) begin
      trace_data_o = pc_q;
      trace_tag_o  = (AW + 1)'(TAG_PC);
      trace_last_o = last_beat;
    end else if (state_q == ST_REGS) begin
      rf_addr_o    = idx_q;
      trace_data_o = rf_data_i;
      trace_tag_o  = {1'b0, idx_q} + 1'b1;
      trace_last_o = last_beat;
    end
  end

  assign trace_valid_o = busy;
  assign stall_o       = stall_q;
  assign record_cnt_o  = cnt_q;
  assign done_o        = (state_q == ST_DONE);
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_trace_dump_unit.sv
// Bench for trace_dump_unit: a full-dump instance checked through a beat scoreboard and a
// PC-only instance checked against a per-cycle vector table.
module tb_trace_dump_unit;
  import trace_pkg::*;

  localparam int NR = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  tag;
    logic        last;
  } beat_t;

  typedef struct {
    logic        commit;
    logic [31:0] pc;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_last;
    logic        exp_stall;
    logic        exp_ovf;
    logic [15:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // full-dump instance
  logic          rst, en, commit, ready;
  logic [31:0]   pc;
  logic [AW-1:0] rf_addr;
  logic [31:0]   rf_data;
  logic          stall, valid, last, done, ovf;
  logic [31:0]   data;
  logic [AW:0]   tag;
  logic [15:0]   cnt;
  logic [31:0]   regs [NR];

  assign rf_data = regs[rf_addr];

  trace_dump_unit #(
    .XLEN(32), .NUM_REGS(NR), .DUMP_REGS(1), .MAX_RECORDS(3), .CNT_W(16)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .commit_i(commit), .pc_i(pc),
    .rf_addr_o(rf_addr), .rf_data_i(rf_data), .stall_o(stall),
    .trace_valid_o(valid), .trace_ready_i(ready), .trace_data_o(data),
    .trace_tag_o(tag), .trace_last_o(last), .record_cnt_o(cnt),
    .done_o(done), .overflow_o(ovf)
  );

  // PC-only instance
  logic        p_rst, p_en, p_commit, p_ready;
  logic [31:0] p_pc;
  logic [1:0]  p_rf_addr;
  logic [31:0] p_rf_data;
  logic        p_stall, p_valid, p_last, p_done, p_ovf;
  logic [31:0] p_data;
  logic [2:0]  p_tag;
  logic [15:0] p_cnt;

  assign p_rf_data = 32'hDEAD_BEEF;

  trace_dump_unit #(
    .XLEN(32), .NUM_REGS(4), .DUMP_REGS(0), .MAX_RECORDS(0), .CNT_W(16)
  ) u_pc (
    .clk_i(clk), .rst_i(p_rst), .enable_i(p_en), .commit_i(p_commit), .pc_i(p_pc),
    .rf_addr_o(p_rf_addr), .rf_data_i(p_rf_data), .stall_o(p_stall),
    .trace_valid_o(p_valid), .trace_ready_i(p_ready), .trace_data_o(p_data),
    .trace_tag_o(p_tag), .trace_last_o(p_last), .record_cnt_o(p_cnt),
    .done_o(p_done), .overflow_o(p_ovf)
  );

  beat_t exp_q[$];
  vec_t  vt[8];

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void push_record(input logic [31:0] p);
    exp_q.push_back(beat_t'{p, 6'd0, 1'b0});
    for (int k = 0; k < NR; k++) begin
      exp_q.push_back(beat_t'{regs[k], 6'(k + 1), (k == NR - 1)});
    end
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic do_commit(input logic [31:0] p, input bit accept);
    commit = 1'b1;
    pc     = p;
    if (accept) push_record(p);
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  task automatic drain(input bit toggle, input int exp_cycles, input logic [15:0] exp_cnt,
                       input logic exp_done);
    int    stall_cnt = 0;
    int    guard     = 0;
    bit    held      = 1'b0;
    bit    first     = 1'b1;
    beat_t h, cur, e;
    ready = 1'b1;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      cur = beat_t'{data, tag, last};
      if (first) begin
        check("first_beat_latency", 64'(valid), 64'd1);
        first = 1'b0;
      end
      if (stall) stall_cnt++;
      if (valid) begin
        if (held) check("held_beat_stable", 64'(cur), 64'(h));
        if (ready) begin
          e = exp_q.pop_front();
          check($sformatf("beat_tag%0d", e.tag), 64'(cur), 64'(e));
          held = 1'b0;
        end else begin
          held = 1'b1;
          h    = cur;
        end
      end
      @(posedge clk); #1;
      guard++;
      if (toggle) ready = !ready;
    end
    if (guard >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d beats still pending", exp_q.size());
      exp_q.delete();
    end
    ready = 1'b1;
    @(negedge clk);
    check("post_record_idle", 64'({stall, valid}), 64'd0);
    check("stall_cycles", 64'(stall_cnt), 64'(exp_cycles));
    check("record_cnt", 64'(cnt), 64'(exp_cnt));
    check("done", 64'(done), 64'(exp_done));
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    beat_t e;

    for (int k = 0; k < NR; k++) regs[k] = 32'h1000 + 32'(k);
    regs[0]  = 32'h0;
    regs[1]  = 32'd5;
    regs[31] = 32'd7;

    // {commit, pc, ready} -> {valid, data, last, stall, overflow, record_cnt}
    vt[0] = '{1'b1, 32'h8,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 16'd0};
    vt[1] = '{1'b1, 32'hC,  1'b1, 1'b1, 32'h8,  1'b1, 1'b1, 1'b0, 16'd0};
    vt[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 16'd1};
    vt[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 16'd1};
    vt[4] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 16'd1};
    vt[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 16'd1};
    vt[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 16'd1};
    vt[7] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 16'd2};

    rst = 1'b1; en = 1'b1; commit = 1'b0; ready = 1'b1; pc = '0;
    p_rst = 1'b1; p_en = 1'b1; p_commit = 1'b0; p_ready = 1'b1; p_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; p_rst = 1'b0;
    @(negedge clk);
    check("reset_state", 64'({valid, stall, done, ovf, last, tag, rf_addr, cnt}), 64'd0);
    check("reset_data", 64'(data), 64'd0);
    check("pc_reset_state", 64'({p_valid, p_stall, p_ovf, p_cnt}), 64'd0);
    @(posedge clk); #1;

    // PC-only records, back-to-back commit overflow, and a held beat
    for (int i = 0; i < 8; i++) begin
      p_commit = vt[i].commit;
      p_pc     = vt[i].pc;
      p_ready  = vt[i].ready;
      @(negedge clk);
      check($sformatf("pc_vec%0d", i),
            64'({p_valid, p_data, p_last, p_stall, p_ovf, p_cnt}),
            64'({vt[i].exp_valid, vt[i].exp_data, vt[i].exp_last, vt[i].exp_stall,
                 vt[i].exp_ovf, vt[i].exp_cnt}));
      @(posedge clk); #1;
    end
    p_commit = 1'b0;

    // full record, ready held high
    do_commit(32'h40, 1'b1);
    drain(1'b0, 33, 16'd1, 1'b0);

    // same record with ready toggling every cycle
    do_commit(32'h40, 1'b1);
    drain(1'b1, 65, 16'd2, 1'b0);

    // commits with tracing disabled are ignored
    en = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      commit = 1'b1;
      pc = $urandom;
      @(negedge clk);
      if (valid || stall) seen++;
      @(posedge clk); #1;
    end
    commit = 1'b0;
    en = 1'b1;
    @(negedge clk);
    check("disabled_no_activity", 64'(seen), 64'd0);
    check("disabled_cnt", 64'(cnt), 64'd2);
    @(posedge clk); #1;

    // overflow mid-record, then reset at tag 10
    do_commit(32'h80, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("rst_rec_tag%0d", e.tag), 64'(beat_t'{data, tag, last}), 64'(e));
      @(posedge clk); #1;
      commit = (i == 2);
    end
    @(negedge clk);
    check("tag10_before_reset", 64'({valid, tag}), 64'({1'b1, 6'd10}));
    check("overflow_set", 64'(ovf), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("after_mid_reset", 64'({valid, stall, ovf, cnt}), 64'd0);
    @(posedge clk); #1;
    do_commit(32'h84, 1'b1);
    drain(1'b0, 33, 16'd1, 1'b0);

    // record limit: three records then DONE, the fourth commit is ignored
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      do_commit(32'h100 + 32'(r * 4), 1'b1);
      drain(1'b0, 33, 16'(r + 1), (r == 2));
      repeat (4) @(posedge clk);
      #1;
    end
    do_commit(32'h10C, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid || stall) seen++;
      @(posedge clk); #1;
    end
    check("done_no_beats", 64'(seen), 64'd0);
    @(negedge clk);
    check("done_final", 64'({done, ovf, cnt}), 64'({1'b1, 1'b0, 16'd3}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
